// File: rtl/md_defs_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Mirrors the decoder's md_cal / md_read / other_reg_wr field values.
package md_defs;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10
    } md_cal_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_LO   = 2'b01,
        RD_HI   = 2'b10
    } md_rd_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_LO   = 2'b01,
        WR_HI   = 2'b10
    } md_wr_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing HI/LO candidates.
// Works on magnitudes so all arithmetic stays unsigned and width-exact.
module md_arith
    import md_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       md_cal,
    input  logic             is_signed,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;

    logic [2*WIDTH-1:0] p_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign is_div   = (md_cal == MD_DIV);
    assign a_neg    = is_signed & a[WIDTH-1];
    assign b_neg    = is_signed & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = is_div & (b == '0);

    // Keep the divider well-defined; the result is discarded on div_zero.
    assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;

    assign p_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign prod  = (a_neg ^ b_neg) ? -p_mag : p_mag;

    assign q_mag = a_mag / b_safe;
    assign r_mag = a_mag % b_safe;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    assign res_hi = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? quot : prod[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, latency counter, read mux.
// Results are computed at start and committed on the last busy edge.
module md_unit
    import md_defs::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       md_cal,
    input  logic             is_signed,
    input  logic [1:0]       other_reg_wr,
    input  logic [1:0]       md_read,
    input  logic             int_req,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] md_out
);

    localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] pending_hi;
    logic [WIDTH-1:0] pending_lo;
    logic             pending_skip;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_zero;
    logic             wr_en;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a         (A),
        .b         (B),
        .md_cal    (md_cal),
        .is_signed (is_signed),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .div_zero  (div_zero)
    );

    assign busy  = (cnt != '0);
    assign start = (md_cal != MD_NONE) & ~busy & ~int_req;
    assign wr_en = (other_reg_wr != WR_NONE) & ~busy & ~int_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            pending_hi   <= '0;
            pending_lo   <= '0;
            pending_skip <= 1'b0;
        end else begin
            if (start) begin
                pending_hi   <= res_hi;
                pending_lo   <= res_lo;
                pending_skip <= div_zero;
                cnt          <= (md_cal == MD_DIV) ? CNT_W'(DIV_LAT)
                                                   : CNT_W'(MULT_LAT);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1) && !pending_skip) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
            end
            if (wr_en) begin
                if (other_reg_wr == WR_HI)
                    hi <= A;
                if (other_reg_wr == WR_LO)
                    lo <= A;
            end
        end
    end

    always_comb begin
        md_out = '0;
        unique case (1'b1)
            (md_read == RD_LO): md_out = lo;
            (md_read == RD_HI): md_out = hi;
            default:            md_out = '0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Inputs change 1ns after posedge; outputs are sampled around negedge.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  md_cal;
    logic        is_signed;
    logic [1:0]  other_reg_wr;
    logic [1:0]  md_read;
    logic        int_req;
    logic        start;
    logic        busy;
    logic [31:0] md_out;

    int errors = 0;
    int checks = 0;

    md_unit dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .md_cal       (md_cal),
        .is_signed    (is_signed),
        .other_reg_wr (other_reg_wr),
        .md_read      (md_read),
        .int_req      (int_req),
        .start        (start),
        .busy         (busy),
        .md_out       (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit must never present MD work while busy.
    always @(negedge clk) begin
        if (!reset && busy) begin
            checks++;
            if (md_cal !== 2'b00 || other_reg_wr !== 2'b00) begin
                errors++;
                $display("FAIL no_issue_while_busy: md_cal=%b wr=%b want 00/00",
                         md_cal, other_reg_wr);
            end
        end
    end

    task automatic check_hilo(input logic [31:0] ehi,
                              input logic [31:0] elo,
                              input string nm);
        md_read = 2'b10;
        #1;
        checks++;
        if (md_out !== ehi) begin
            errors++;
            $display("FAIL %s_hi: got %h want %h", nm, md_out, ehi);
        end
        md_read = 2'b01;
        #1;
        checks++;
        if (md_out !== elo) begin
            errors++;
            $display("FAIL %s_lo: got %h want %h", nm, md_out, elo);
        end
        md_read = 2'b00;
    endtask

    task automatic run_op(input logic [1:0] cal, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string nm);
        @(posedge clk); #1;
        md_cal = cal;
        is_signed = sgn;
        A = a;
        B = b;
        @(negedge clk);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: got %b want 1", nm, start);
        end
        @(posedge clk); #1;
        md_cal = 2'b00;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_T+%0d: got %b want 1", nm, i, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_T+%0d: got %b want 0", nm, lat + 1, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A = '0; B = '0; md_cal = 2'b00; is_signed = 1'b0;
        other_reg_wr = 2'b00; md_read = 2'b00; int_req = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b start=%b want 0/0", busy, start);
        end
        check_hilo(32'h0, 32'h0, "reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        run_op(2'b01, 1'b1, 32'hFFFF_FFFE, 32'h3, 5, "mult");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(2'b01, 1'b0, 32'hFFFF_FFFE, 32'h3, 5, "multu");
        check_hilo(32'h0000_0002, 32'hFFFF_FFFA, "multu");
    endtask

    task automatic test_div();
        run_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'h2, 10, "div");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(2'b10, 1'b0, 32'h7, 32'h2, 10, "divu");
        check_hilo(32'h1, 32'h3, "divu");
        run_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        check_hilo(32'h0, 32'h8000_0000, "div_ovf");
    endtask

    task automatic test_div_zero();
        @(posedge clk); #1;
        other_reg_wr = 2'b10;
        A = 32'h1234_5678;
        md_read = 2'b10;
        #1;
        checks++;
        if (md_out !== 32'h0) begin
            errors++;
            $display("FAIL mthi_no_bypass: got %h want 00000000", md_out);
        end
        md_read = 2'b00;
        @(posedge clk); #1;
        other_reg_wr = 2'b01;
        A = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        other_reg_wr = 2'b00;
        @(negedge clk);
        check_hilo(32'h1234_5678, 32'h9ABC_DEF0, "mthi_mtlo");
        run_op(2'b10, 1'b0, 32'h5, 32'h0, 10, "div0");
        check_hilo(32'h1234_5678, 32'h9ABC_DEF0, "div0");
    endtask

    task automatic test_int_req();
        @(posedge clk); #1;
        md_cal = 2'b01;
        is_signed = 1'b0;
        A = 32'h5;
        B = 32'h7;
        int_req = 1'b1;
        @(negedge clk);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL int_start: got %b want 0", start);
        end
        @(posedge clk); #1;
        md_cal = 2'b00;
        other_reg_wr = 2'b01;
        A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        other_reg_wr = 2'b00;
        int_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL int_busy: got %b want 0", busy);
        end
        check_hilo(32'h1234_5678, 32'h9ABC_DEF0, "int_hold");
        run_op(2'b01, 1'b0, 32'h5, 32'h7, 5, "after_int");
        check_hilo(32'h0, 32'h23, "after_int");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        md_cal = 2'b01;
        is_signed = 1'b0;
        A = 32'h0001_0000;
        B = 32'h0001_0003;
        @(posedge clk); #1;
        md_cal = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_pre: got %b want 1", busy);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: got %b want 0", busy);
        end
        check_hilo(32'h0, 32'h0, "rst_mid");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_busy: got %b want 0", busy);
        end
        check_hilo(32'h0, 32'h0, "rst_mid_late");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_int_req();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- Consumes the decoder's md_cal, md_read, other_reg_wr and is_signed controls together with forwarded rs/rt values.
- Holds the architectural HI/LO registers and models mult/div latency with a busy counter.
- Drives busy/start to the hazard unit, which stalls later MD instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- A  input  WIDTH  forwarded rs value.
- B  input  WIDTH  forwarded rt value.
- md_cal  input  2  MD_NONE 00 / MD_MULT 01 / MD_DIV 10.
- is_signed  input  1  signed operation (mult/div).
- other_reg_wr  input  2  WR_NONE 00 / WR_LO 01 / WR_HI 10.
- md_read  input  2  RD_NONE 00 / RD_LO 01 / RD_HI 10.
- int_req  input  1  exception/interrupt flush from CP0; suppresses start/writes this cycle.
- start  output  1  combinational: operation accepted this cycle.
- busy  output  1  registered: operation in flight.
- md_out  output  WIDTH  combinational HI/LO read data for mfhi/mflo.

Behaviour:
- Reset (async): HI=0, LO=0, cnt=0, pending results=0. busy=0 immediately; start and md_out follow combinationally (0 with idle inputs).
- start = (md_cal!=MD_NONE) & !busy & !int_req.
- On the start edge (cycle T):
  - Compute results from A/B into pending_hi/pending_lo.
  - Load cnt = MULT_LAT or DIV_LAT.
- busy = (cnt!=0): high in cycles T+1..T+LAT.
- Each busy cycle cnt decrements. On the edge where cnt==1, pending is committed to HI/LO, so new values are visible from cycle T+LAT+1.
- mult: 64-bit product; HI = [63:32], LO = [31:0]. Signed if is_signed, else unsigned.
- div:
  - LO = quotient, truncated toward zero; HI = remainder, sign of dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: the op still runs DIV_LAT busy cycles, but HI/LO are NOT updated at commit.
- md_cal asserted while busy: ignored, no restart. The hazard unit must stall; the bench asserts this never happens.
- mthi/mtlo:
  - When other_reg_wr!=WR_NONE & !busy & !int_req, the selected register takes A at the next edge.
  - Ignored while busy, with the same assertion.
- md_out: RD_LO gives LO, RD_HI gives HI, else 0.
  - Reflects registered values only; a same-cycle mthi is not bypassed.
  - Reads while busy return the old HI/LO; the hazard unit stalls mfhi/mflo on start|busy.
- int_req:
  - Blocks acceptance in the same cycle (start=0, no mthi/mtlo write).
  - Does not cancel an op already in flight; that op commits normally.
- Reset mid-operation: pending result discarded, HI/LO cleared, busy drops asynchronously.

Decomposition:
- Shared package md_defs holds:
  - MD_NONE/MD_MULT/MD_DIV, RD_NONE/RD_LO/RD_HI, WR_NONE/WR_LO/WR_HI encodings.
  - Default MULT_LAT/DIV_LAT.
  - Extends the existing head.v macro set.
- One sub-module: md_arith. Purely combinational; (A, B, md_cal, is_signed) -> (res_hi, res_lo, div_zero).
- md_unit keeps the counter, pending regs, HI/LO and the read mux.

Test Plan:
- mult, is_signed=1, A=0xFFFFFFFE, B=3 at T: start=1 at T; busy=1 T+1..T+5, 0 at T+6; mfhi→0xFFFFFFFF, mflo→0xFFFFFFFA.
- multu, same operands: HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div signed, A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu A=7, B=2: LO=3, HI=1.
- Divide by zero after mthi 0x12345678 / mtlo 0x9ABCDEF0: busy 10 cycles, then HI=0x12345678, LO=0x9ABCDEF0 unchanged.
- md_cal=MD_MULT with int_req=1: start=0, busy stays 0, HI/LO unchanged. Next cycle without int_req: starts normally.
- Reset pulsed at busy cycle 3 of a mult: busy=0 and HI=LO=0 within the same cycle; no later commit.
